// File: rtl/subleq_trace_uart_if.sv
// CPU debug bus seen by the tracer: CPU clock plus the registers to snapshot.
// Latency: none (wires only).
// Backpressure: none; the tracer samples whenever it sees an iStep rise.
interface subleq_trace_uart_if;
  logic        iStep;
  logic [2:0]  icounter;
  logic [31:0] iIP;
  logic [31:0] iA;
  logic [31:0] iB;
  logic [31:0] iJ;
  logic [31:0] iq;
  logic [31:0] isub;
  logic        ileq;

  modport master (output iStep, icounter, iIP, iA, iB, iJ, iq, isub, ileq);
  modport slave  (input  iStep, icounter, iIP, iA, iB, iJ, iq, isub, ileq);
endinterface

// File: rtl/subleq_trace_uart.sv
// Snapshots subleq CPU state on each iStep rise and sends it as one 59-char ASCII hex line, 8N1.
// Latency: start bit 4 iClock edges after iStep is first sampled high; frame = 59*(10*DIVISOR+1) cycles.
// Backpressure: none; captures arriving while busy are discarded and counted in oDropped (saturating).
module subleq_trace_uart #(
  parameter int unsigned DIVISOR = 434
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  subleq_trace_uart_if.slave dbg,
  output logic               oTx,
  output logic               oBusy,
  output logic [7:0]         oDropped
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  localparam logic [15:0] BIT_LAST  = 16'(DIVISOR - 1);
  localparam logic [5:0]  LAST_CHAR = 6'd58;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [5:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic [7:0]  drop_q;
  logic        s1_q, s2_q, s3_q;
  logic        trig, capture;

  logic [2:0]  snap_cnt;
  logic [31:0] snap_w [6];
  logic        snap_leq;

  logic [3:0]  nib;
  logic        use_hex;
  logic [7:0]  ch;

  // Only iStep crosses domains; the data buses settle long before trig fires.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= dbg.iStep;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign trig    = s2_q & ~s3_q;
  assign capture = trig & iEnable & (state_q == IDLE);

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      snap_cnt <= '0;
      snap_leq <= 1'b0;
      for (int i = 0; i < 6; i++) snap_w[i] <= '0;
    end else if (capture) begin
      snap_cnt  <= dbg.icounter;
      snap_leq  <= dbg.ileq;
      snap_w[0] <= dbg.iIP;
      snap_w[1] <= dbg.iA;
      snap_w[2] <= dbg.iB;
      snap_w[3] <= dbg.iJ;
      snap_w[4] <= dbg.iq;
      snap_w[5] <= dbg.isub;
    end
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      drop_q <= '0;
    end else if (trig && iEnable && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  // Line layout: cnt SP w0 SP w1 SP w2 SP w3 SP w4 SP w5 SP leq CR LF; word f digit d sits at 2+9f+d.
  always_comb begin
    ch      = 8'h20;
    nib     = '0;
    use_hex = 1'b0;
    case (idx_q)
      6'd0:  begin nib = {1'b0, snap_cnt}; use_hex = 1'b1; end
      6'd56: begin nib = {3'b0, snap_leq}; use_hex = 1'b1; end
      6'd57: ch = 8'h0D;
      6'd58: ch = 8'h0A;
      default: begin
        for (int f = 0; f < 6; f++) begin
          for (int d = 0; d < 8; d++) begin
            if (idx_q == 6'(2 + 9 * f + d)) begin
              nib     = snap_w[f][31 - 4 * d -: 4];
              use_hex = 1'b1;
            end
          end
        end
      end
    endcase
    if (use_hex) begin
      ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        sh_d    = ch;
        tx_d    = 1'b0;
        cnt_d   = BIT_LAST;
        state_d = START;
      end
      START: begin
        if (cnt_q == '0) begin
          tx_d    = sh_q[0];
          sh_d    = {1'b1, sh_q[7:1]};
          bit_d   = '0;
          cnt_d   = BIT_LAST;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BIT_LAST;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d  = sh_q[0];
            sh_d  = {1'b1, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (idx_q < LAST_CHAR) begin
            idx_d   = idx_q + 6'd1;
            state_d = LOAD;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign oTx      = tx_q;
  assign oBusy    = busy_q;
  assign oDropped = drop_q;

endmodule
